// File: rtl/tlb_maint_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package : tlb_maint_unit_pkg
// Brief   : Shared TLB entry types, maintenance op encoding and INVTLB op codes
// Rev     : 1.0 - initial release
// ============================================================================
package tlb_maint_unit_pkg;

    typedef struct packed {
        logic        e;
        logic [9:0]  asid;
        logic        g;
        logic [5:0]  ps;
        logic [18:0] vppn;
    } tlb_key_t;

    typedef struct packed {
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } tlb_data_t;

    typedef struct packed {
        tlb_key_t  key;
        tlb_data_t data;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        TLB_OP_WR   = 2'd0,
        TLB_OP_FILL = 2'd1,
        TLB_OP_INV  = 2'd2,
        TLB_OP_RSVD = 2'd3
    } tlb_maint_op_t;

    localparam logic [4:0] INV_ALL0       = 5'd0;
    localparam logic [4:0] INV_ALL1       = 5'd1;
    localparam logic [4:0] INV_G1         = 5'd2;
    localparam logic [4:0] INV_G0         = 5'd3;
    localparam logic [4:0] INV_G0_ASID    = 5'd4;
    localparam logic [4:0] INV_G0_ASID_VA = 5'd5;
    localparam logic [4:0] INV_GA_VA      = 5'd6;

    // Page size code of a 4 MB page
    localparam logic [5:0] c_ps_4m = 6'd22;

    // Op codes above INV_GA_VA raise an instruction-not-exist exception
    function automatic logic is_inv_op_legal(input logic [4:0] op);
        return op <= INV_GA_VA;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlb_maint_unit_inv_match.sv
`default_nettype none
// ============================================================================
// Module : tlb_inv_match
// Brief  : INVTLB match decision for one TLB entry against latched operands
// Rev    : 1.0 - initial release
// ============================================================================
module tlb_inv_match
    import tlb_maint_unit_pkg::*;
#(
    parameter int TLB_SUPPORT_4M_PAGE = 0
) (
    input  tlb_key_t    i_key,
    input  logic [4:0]  i_op,
    input  logic [9:0]  i_asid,
    input  logic [18:0] i_vpn,    // vaddr[31:13]
    output logic        o_match
);

    logic w_asid_hit;
    logic w_va_hit;

    // VA compare: 4 MB pages only look at vaddr[31:23] (vpn[18:10])
    always_comb begin
        w_asid_hit = (i_key.asid == i_asid);
        w_va_hit   = (i_key.vppn == i_vpn);
        if ((TLB_SUPPORT_4M_PAGE != 0) && (i_key.ps == c_ps_4m)) begin
            w_va_hit = (i_key.vppn[18:10] == i_vpn[18:10]);
        end
    end

    // Op-dependent selection, gated by the entry's valid bit
    always_comb begin
        o_match = 1'b0;
        case (i_op)
            INV_ALL0, INV_ALL1: o_match = 1'b1;
            INV_G1:             o_match = i_key.g;
            INV_G0:             o_match = ~i_key.g;
            INV_G0_ASID:        o_match = ~i_key.g & w_asid_hit;
            INV_G0_ASID_VA:     o_match = ~i_key.g & w_asid_hit & w_va_hit;
            INV_GA_VA:          o_match = (i_key.g | w_asid_hit) & w_va_hit;
            default:            o_match = 1'b0;
        endcase
        o_match = o_match & i_key.e;
    end

endmodule
`default_nettype wire

// File: rtl/tlb_maint_unit.sv
`default_nettype none
// ============================================================================
// Module : tlb_maint_unit
// Brief  : Owns the TLB entry array; performs TLBWR, TLBFILL and the
//          multi-cycle INVTLB sweep, one request in flight at a time
// Rev    : 1.0 - initial release
// ============================================================================
module tlb_maint_unit
    import tlb_maint_unit_pkg::*;
#(
    parameter int TLB_ENTRY_NUM       = 32,
    parameter int TLB_SUPPORT_4M_PAGE = 0,
    parameter int INV_LANES           = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic [1:0]                       req_op_i,
    input  logic [$clog2(TLB_ENTRY_NUM)-1:0] wr_index_i,
    input  tlb_entry_t                       wr_entry_i,
    input  logic [4:0]                       inv_op_i,
    input  logic [9:0]                       inv_asid_i,
    input  logic [31:0]                      inv_vaddr_i,
    output tlb_entry_t                       entries_o [TLB_ENTRY_NUM],
    output logic [$clog2(TLB_ENTRY_NUM)-1:0] fill_index_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             inv_err_o
);

    localparam int                 c_idx_w     = $clog2(TLB_ENTRY_NUM);
    localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(TLB_ENTRY_NUM - INV_LANES);
    localparam logic [c_idx_w-1:0] c_lane_step = c_idx_w'(INV_LANES);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_sweep = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    tlb_entry_t         r_entries [TLB_ENTRY_NUM];
    logic [c_idx_w-1:0] r_fill_ptr;
    logic [c_idx_w-1:0] r_fill_index;
    logic [c_idx_w-1:0] r_sweep_idx;
    logic [4:0]         r_inv_op;
    logic [9:0]         r_inv_asid;
    logic [18:0]        r_inv_vpn;
    logic               r_done;
    logic               r_inv_err;

    logic               w_accept;
    logic               w_inv_legal;
    logic               w_last_group;
    logic [INV_LANES-1:0] w_match;
    logic [c_idx_w-1:0] w_lane_idx [INV_LANES];
    logic               w_unused_vaddr_lsbs;

    assign w_accept            = req_valid_i && (r_state == c_st_idle);
    assign w_inv_legal         = is_inv_op_legal(inv_op_i);
    assign w_last_group        = (r_sweep_idx == c_last_idx);
    // Page offset bits never take part in a VA compare
    assign w_unused_vaddr_lsbs = ^inv_vaddr_i[12:0];

    assign req_ready_o  = (r_state == c_st_idle);
    assign busy_o       = (r_state == c_st_sweep);
    assign done_o       = r_done;
    assign inv_err_o    = r_inv_err;
    assign fill_index_o = r_fill_index;
    assign entries_o    = r_entries;

    // One matcher per lane, looking at the current group of the sweep
    for (genvar l = 0; l < INV_LANES; l++) begin : g_lane
        assign w_lane_idx[l] = r_sweep_idx + c_idx_w'(l);

        tlb_inv_match #(
            .TLB_SUPPORT_4M_PAGE(TLB_SUPPORT_4M_PAGE)
        ) u_match (
            .i_key   (r_entries[w_lane_idx[l]].key),
            .i_op    (r_inv_op),
            .i_asid  (r_inv_asid),
            .i_vpn   (r_inv_vpn),
            .o_match (w_match[l])
        );
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: only a legal INVTLB leaves IDLE; the last group returns
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept && (req_op_i == TLB_OP_INV) && w_inv_legal) begin
                    w_state_nxt = c_st_sweep;
                end
            end
            c_st_sweep: begin
                if (w_last_group) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Array mutation, fill pointer, operand latches and completion pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TLB_ENTRY_NUM; i++) begin
                r_entries[i] <= '0;
            end
            r_fill_ptr   <= '0;
            r_fill_index <= '0;
            r_sweep_idx  <= '0;
            r_inv_op     <= '0;
            r_inv_asid   <= '0;
            r_inv_vpn    <= '0;
            r_done       <= 1'b0;
            r_inv_err    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_inv_err <= 1'b0;
            if (w_accept) begin
                case (req_op_i)
                    TLB_OP_WR: begin
                        r_entries[wr_index_i] <= wr_entry_i;
                        r_done                <= 1'b1;
                    end
                    TLB_OP_FILL: begin
                        r_entries[r_fill_ptr] <= wr_entry_i;
                        r_fill_index          <= r_fill_ptr;
                        r_fill_ptr            <= r_fill_ptr + 1'b1;
                        r_done                <= 1'b1;
                    end
                    TLB_OP_INV: begin
                        if (w_inv_legal) begin
                            r_inv_op    <= inv_op_i;
                            r_inv_asid  <= inv_asid_i;
                            r_inv_vpn   <= inv_vaddr_i[31:13];
                            r_sweep_idx <= '0;
                        end else begin
                            r_inv_err <= 1'b1;
                            r_done    <= 1'b1;
                        end
                    end
                    default: r_done <= 1'b1;
                endcase
            end
            if (r_state == c_st_sweep) begin
                for (int l = 0; l < INV_LANES; l++) begin
                    if (w_match[l]) begin
                        r_entries[w_lane_idx[l]].key.e <= 1'b0;
                    end
                end
                r_sweep_idx <= r_sweep_idx + c_lane_step;
                if (w_last_group) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tlb_maint_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_tlb_maint_unit
// Brief  : Scoreboard bench for tlb_maint_unit (expected responses queued at
//          issue, compared by a monitor on every done_o)
// Rev    : 1.0 - initial release
// ============================================================================
module tb_tlb_maint_unit;
    import tlb_maint_unit_pkg::*;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [4:0]  wr_index;
    tlb_entry_t  wr_entry;
    logic [4:0]  inv_op;
    logic [9:0]  inv_asid;
    logic [31:0] inv_vaddr;
    tlb_entry_t  entries [N];
    logic [4:0]  fill_index;
    logic        busy;
    logic        done;
    logic        inv_err;

    always #5 clk = ~clk;

    tlb_maint_unit #(
        .TLB_ENTRY_NUM       (N),
        .TLB_SUPPORT_4M_PAGE (1),
        .INV_LANES           (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .wr_index_i   (wr_index),
        .wr_entry_i   (wr_entry),
        .inv_op_i     (inv_op),
        .inv_asid_i   (inv_asid),
        .inv_vaddr_i  (inv_vaddr),
        .entries_o    (entries),
        .fill_index_o (fill_index),
        .busy_o       (busy),
        .done_o       (done),
        .inv_err_o    (inv_err)
    );

    typedef struct {
        logic               inv_err;
        logic [4:0]         fill_idx;
        int                 busy_cycles;
        tlb_entry_t [N-1:0] ents;
        int                 tag;
    } exp_t;

    exp_t       sb_q [$];
    tlb_entry_t m_ent [N];
    logic [4:0] m_fill_ptr;
    logic [4:0] m_fill_idx;
    int         checks   = 0;
    int         failures = 0;
    int         tag_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic tlb_entry_t mk(input logic e, input logic g, input logic [9:0] asid,
                                      input logic [18:0] vppn, input logic [5:0] ps);
        tlb_entry_t t;
        t           = '0;
        t.key.e     = e;
        t.key.g     = g;
        t.key.asid  = asid;
        t.key.vppn  = vppn;
        t.key.ps    = ps;
        t.data.ppn0 = {1'b0, vppn} ^ 20'hA5A5A;
        t.data.ppn1 = 20'h0F0F0 ^ {10'd0, asid};
        t.data.v0   = 1'b1;
        t.data.mat1 = 2'b01;
        return t;
    endfunction

    // Reference INVTLB predicate (4 MB page support enabled in this bench)
    function automatic bit m_match(input tlb_entry_t t, input logic [4:0] op,
                                   input logic [9:0] asid, input logic [31:0] va);
        bit va_hit;
        bit asid_hit;
        if (t.key.ps == 6'd22) va_hit = (t.key.vppn[18:10] == va[31:23]);
        else                   va_hit = (t.key.vppn == va[31:13]);
        asid_hit = (t.key.asid == asid);
        if (!t.key.e) return 1'b0;
        case (op)
            5'd0, 5'd1: return 1'b1;
            5'd2:       return t.key.g;
            5'd3:       return !t.key.g;
            5'd4:       return !t.key.g && asid_hit;
            5'd5:       return !t.key.g && asid_hit && va_hit;
            5'd6:       return (t.key.g || asid_hit) && va_hit;
            default:    return 1'b0;
        endcase
    endfunction

    // Drive one request (called at a negedge); queue the expected response
    task automatic issue(input logic [1:0] op, input logic [4:0] idx, input tlb_entry_t ent,
                         input logic [4:0] iop, input logic [9:0] asid, input logic [31:0] va,
                         input bit push);
        exp_t e;
        chk("ready_at_issue", 32'(req_ready), 32'd1);
        e.inv_err     = 1'b0;
        e.busy_cycles = 0;
        case (op)
            2'd0: m_ent[idx] = ent;
            2'd1: begin
                m_ent[m_fill_ptr] = ent;
                m_fill_idx        = m_fill_ptr;
                m_fill_ptr        = m_fill_ptr + 5'd1;
            end
            2'd2: begin
                if (iop > 5'd6) begin
                    e.inv_err = 1'b1;
                end else begin
                    e.busy_cycles = N / 4;
                    for (int i = 0; i < N; i++)
                        if (m_match(m_ent[i], iop, asid, va)) m_ent[i].key.e = 1'b0;
                end
            end
            default: ;
        endcase
        e.fill_idx = m_fill_idx;
        for (int i = 0; i < N; i++) e.ents[i] = m_ent[i];
        e.tag = tag_cnt;
        tag_cnt++;
        if (push) sb_q.push_back(e);
        req_valid = 1'b1;
        req_op    = op;
        wr_index  = idx;
        wr_entry  = ent;
        inv_op    = iop;
        inv_asid  = asid;
        inv_vaddr = va;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d expected=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Monitor: count busy cycles, compare every completion against the queue
    initial begin : monitor
        int   busy_cnt;
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (inv_err) chk("inv_err_with_done", 32'(done), 32'd1);
                if (done) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done actual=1 expected=0");
                    end else begin
                        int bad;
                        e = sb_q.pop_front();
                        chk($sformatf("inv_err[%0d]", e.tag), 32'(inv_err), 32'(e.inv_err));
                        chk($sformatf("fill_index[%0d]", e.tag), 32'(fill_index), 32'(e.fill_idx));
                        chk($sformatf("busy_cycles[%0d]", e.tag), 32'(busy_cnt), 32'(e.busy_cycles));
                        bad = -1;
                        for (int i = 0; i < N; i++)
                            if (bad < 0 && entries[i] !== e.ents[i]) bad = i;
                        checks++;
                        if (bad >= 0) begin
                            failures++;
                            $display("FAIL entries[%0d] idx=%0d actual=%0h expected=%0h",
                                     e.tag, bad, entries[bad], e.ents[bad]);
                        end
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin : stimulus
        int nz;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        wr_index  = '0;
        wr_entry  = '0;
        inv_op    = '0;
        inv_asid  = '0;
        inv_vaddr = '0;
        for (int i = 0; i < N; i++) m_ent[i] = '0;
        m_fill_ptr = '0;
        m_fill_idx = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        nz = 0;
        for (int i = 0; i < N; i++) if (entries[i] !== '0) nz++;
        chk("reset_entries_nonzero", 32'(nz), 32'd0);
        chk("reset_fill_index", 32'(fill_index), 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_inv_err", 32'(inv_err), 32'd0);

        // Indexed write
        issue(TLB_OP_WR, 5'd5, mk(1'b1, 1'b0, 10'd3, 19'h12345, 6'd12), 5'd0, 10'd0, 32'd0, 1'b1);
        chk("wr_done_next_cycle", 32'(done), 32'd1);
        wait_drain();

        // 33 back-to-back fills: index 0..31 then wraps to 0
        for (int i = 0; i < 33; i++)
            issue(TLB_OP_FILL, 5'd0, mk(1'b1, 1'b1, 10'(i + 100), 19'(i + 1), 6'd12),
                  5'd0, 10'd0, 32'd0, 1'b1);
        wait_drain();

        // Selective invalidate op 4, asid 7
        issue(TLB_OP_WR, 5'd0, mk(1'b1, 1'b1, 10'd0, 19'h00000, 6'd12), 5'd0, 10'd0, 32'd0, 1'b1);
        issue(TLB_OP_WR, 5'd1, mk(1'b1, 1'b0, 10'd7, 19'h00111, 6'd12), 5'd0, 10'd0, 32'd0, 1'b1);
        issue(TLB_OP_WR, 5'd2, mk(1'b1, 1'b0, 10'd9, 19'h00222, 6'd12), 5'd0, 10'd0, 32'd0, 1'b1);
        issue(TLB_OP_WR, 5'd3, mk(1'b1, 1'b0, 10'd7, 19'h40000, 6'd12), 5'd0, 10'd0, 32'd0, 1'b1);
        issue(TLB_OP_INV, 5'd0, '0, 5'd4, 10'd7, 32'd0, 1'b1);
        chk("inv_ready_low", 32'(req_ready), 32'd0);
        wait_drain();

        // op 6 on a 4 MB page entry: invalidated; same with ps=12: kept
        issue(TLB_OP_WR, 5'd10, mk(1'b1, 1'b1, 10'h55, 19'h7FC00, 6'd22), 5'd0, 10'd0, 32'd0, 1'b1);
        issue(TLB_OP_INV, 5'd0, '0, 5'd6, 10'd3, 32'hFF9FF000, 1'b1);
        wait_drain();
        issue(TLB_OP_WR, 5'd10, mk(1'b1, 1'b1, 10'h55, 19'h7FC00, 6'd12), 5'd0, 10'd0, 32'd0, 1'b1);
        issue(TLB_OP_INV, 5'd0, '0, 5'd6, 10'd3, 32'hFF9FF000, 1'b1);
        wait_drain();

        // op 5: non-global, asid and 4 KB VA match
        issue(TLB_OP_WR, 5'd11, mk(1'b1, 1'b0, 10'h21, 19'h7FCFF, 6'd12), 5'd0, 10'd0, 32'd0, 1'b1);
        issue(TLB_OP_INV, 5'd0, '0, 5'd5, 10'h21, 32'hFF9FF123, 1'b1);
        wait_drain();

        // Illegal INVTLB op and the reserved maintenance op
        issue(TLB_OP_INV, 5'd0, '0, 5'd9, 10'd7, 32'd0, 1'b1);
        chk("illegal_inv_err_pulse", 32'(inv_err), 32'd1);
        chk("illegal_ready_stays", 32'(req_ready), 32'd1);
        chk("illegal_not_busy", 32'(busy), 32'd0);
        wait_drain();
        issue(TLB_OP_RSVD, 5'd4, mk(1'b1, 1'b0, 10'd1, 19'h1, 6'd12), 5'd0, 10'd0, 32'd0, 1'b1);
        wait_drain();

        // op 3: every valid non-global entry
        issue(TLB_OP_INV, 5'd0, '0, 5'd3, 10'd0, 32'd0, 1'b1);
        wait_drain();

        // Reset in the third sweep cycle of op 0 aborts the sweep
        issue(TLB_OP_INV, 5'd0, '0, 5'd0, 10'd0, 32'd0, 1'b0);
        chk("abort_busy_high", 32'(busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) m_ent[i] = '0;
        m_fill_ptr = '0;
        m_fill_idx = '0;
        nz = 0;
        for (int i = 0; i < N; i++) if (entries[i] !== '0) nz++;
        chk("abort_entries_zero", 32'(nz), 32'd0);
        chk("abort_no_done", 32'(done), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_busy_low", 32'(busy), 32'd0);
        repeat (12) @(negedge clk);

        // Fill pointer restarts at 0 after reset
        issue(TLB_OP_FILL, 5'd0, mk(1'b1, 1'b0, 10'd2, 19'h00ABC, 6'd12), 5'd0, 10'd0, 32'd0, 1'b1);
        issue(TLB_OP_FILL, 5'd0, mk(1'b1, 1'b1, 10'd4, 19'h00DEF, 6'd12), 5'd0, 10'd0, 32'd0, 1'b1);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
